// File: rtl/vend_pkg.sv
// vend_pkg: key codes, coin values and FSM state type for the vending command decoder
package vend_pkg;
  localparam logic [7:0] KEY_COIN1    = 8'h31;
  localparam logic [7:0] KEY_COIN5    = 8'h35;
  localparam logic [7:0] KEY_COIN10   = 8'h30;
  localparam logic [7:0] KEY_SEL_BASE = 8'h41;
  localparam logic [7:0] KEY_CANCEL   = 8'h63;
  localparam logic [7:0] ACK_OK       = 8'h4B;
  localparam logic [7:0] ACK_ERR      = 8'h45;
  localparam logic [7:0] COIN1_VAL    = 8'd1;
  localparam logic [7:0] COIN5_VAL    = 8'd5;
  localparam logic [7:0] COIN10_VAL   = 8'd10;
  typedef enum logic [1:0] {IDLE, DISPENSE, REFUND} vend_state_t;
endpackage

// File: rtl/vend_hold_timer.sv
// vend_hold_timer: counts CYCLES clocks after start, done is high on the last one
module vend_hold_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);
  logic [W-1:0] cnt;
  logic run;
  assign done = run && cnt == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      cnt <= done ? '0 : cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/vend_cmd_decoder.sv
// vend_cmd_decoder: UART byte to vending action decoder; `define VEND_CMD_ECHO_EN adds a K/E echo
module vend_cmd_decoder
  import vend_pkg::*;
#(
  parameter logic [7:0] PRICE           = 8'd15,
  parameter logic [7:0] CREDIT_MAX      = 8'd99,
  parameter int         DISPENSE_CYCLES = 100_000_000,
  parameter int         NUM_ITEMS       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] credit,
  output logic       dispense,
  output logic [1:0] item,
  output logic [7:0] change,
  output logic       change_valid,
`ifdef VEND_CMD_ECHO_EN
  output logic       error,
  output logic [7:0] tx_byte,
  output logic       tx_valid
`else
  output logic       error
`endif
);
  vend_state_t state;
  logic [7:0] val, sel_off;
  logic [8:0] sum;
  logic is_coin, is_sel, is_cancel, err_c, buy, done;
  always_comb begin
    val = rx_byte == KEY_COIN1 ? COIN1_VAL :
          rx_byte == KEY_COIN5 ? COIN5_VAL :
          rx_byte == KEY_COIN10 ? COIN10_VAL : 8'd0;
    is_coin = val != 8'd0;
    sel_off = rx_byte - KEY_SEL_BASE;
    is_sel = rx_byte >= KEY_SEL_BASE && 32'(sel_off) < NUM_ITEMS;
    is_cancel = rx_byte == KEY_CANCEL;
    sum = {1'b0, credit} + {1'b0, val};
    err_c = rx_valid && (state != IDLE || (is_coin && sum > {1'b0, CREDIT_MAX}) ||
            (is_sel && credit < PRICE) || !(is_coin || is_sel || is_cancel));
    buy = state == IDLE && rx_valid && is_sel && !err_c;
  end
  vend_hold_timer #(.CYCLES(DISPENSE_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .start(buy), .done(done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= 8'd0;
      dispense     <= 1'b0;
      item         <= 2'd0;
      change       <= 8'd0;
      change_valid <= 1'b0;
      error        <= 1'b0;
`ifdef VEND_CMD_ECHO_EN
      tx_byte      <= 8'd0;
      tx_valid     <= 1'b0;
`endif
    end else begin
      error        <= err_c;
      change_valid <= 1'b0;
`ifdef VEND_CMD_ECHO_EN
      tx_valid     <= rx_valid;
      if (rx_valid) tx_byte <= err_c ? ACK_ERR : ACK_OK;
`endif
      case (state)
        IDLE: if (rx_valid && !err_c) begin
          if (is_coin) credit <= sum[7:0];
          else if (is_sel) begin
            item     <= sel_off[1:0];
            change   <= credit - PRICE;
            credit   <= 8'd0;
            dispense <= 1'b1;
            state    <= DISPENSE;
          end else if (credit != 8'd0) begin
            change       <= credit;
            credit       <= 8'd0;
            change_valid <= 1'b1;
            state        <= REFUND;
          end
        end
        DISPENSE: if (done) begin
          dispense     <= 1'b0;
          change_valid <= change != 8'd0;
          state        <= change != 8'd0 ? REFUND : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_cmd_decoder.sv
// tb_vend_cmd_decoder: table-driven plus directed checks with DISPENSE_CYCLES=4
module tb_vend_cmd_decoder;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic [7:0] credit, change;
  logic [1:0] item;
  logic dispense, change_valid, error;
`ifdef VEND_CMD_ECHO_EN
  logic [7:0] tx_byte;
  logic tx_valid;
`endif
  int checks = 0, errors = 0;

  vend_cmd_decoder #(.DISPENSE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .credit(credit), .dispense(dispense), .item(item), .change(change),
    .change_valid(change_valid),
`ifdef VEND_CMD_ECHO_EN
    .error(error), .tx_byte(tx_byte), .tx_valid(tx_valid)
`else
    .error(error)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] b; logic [7:0] cr; logic er;} vec_t;
  vec_t v[0:19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send(v[i].b);
      chk($sformatf("credit[%0d]", i), 32'(credit), 32'(v[i].cr));
      chk($sformatf("error[%0d]", i), 32'(error), 32'(v[i].er));
    end
  endtask

  task automatic measure(output int width, output int cvn, output logic [7:0] cvc);
    width = 0;
    cvn = 0;
    cvc = 8'd0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (dispense) width++;
      if (change_valid) begin
        cvn++;
        cvc = change;
      end
    end
  endtask

  initial begin
    int w, n;
    logic [7:0] c;
    v[0] = '{8'h35, 8'd5, 1'b0};
    v[1] = '{8'h35, 8'd10, 1'b0};
    v[2] = '{8'h35, 8'd15, 1'b0};
    v[3] = '{8'h30, 8'd10, 1'b0};
    v[4] = '{8'h35, 8'd15, 1'b0};
    v[5] = '{8'h31, 8'd16, 1'b0};
    v[6] = '{8'h31, 8'd1, 1'b0};
    v[7] = '{8'h43, 8'd1, 1'b1};
    for (int i = 8; i <= 16; i++) v[i] = '{8'h30, 8'((i - 7) * 10), 1'b0};
    v[17] = '{8'h30, 8'd90, 1'b1};
    v[18] = '{8'h35, 8'd95, 1'b0};
    v[19] = '{8'h78, 8'd95, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_dispense", 32'(dispense), 0);
    chk("rst_item", 32'(item), 0);
    chk("rst_change", 32'(change), 0);
    chk("rst_cv", 32'(change_valid), 0);
    chk("rst_error", 32'(error), 0);
    rst = 1'b0;

    run_table(0, 2);
    send(8'h41);
    chk("buyA_credit", 32'(credit), 0);
    chk("buyA_item", 32'(item), 0);
    measure(w, n, c);
    chk("buyA_width", 32'(w), 4);
    chk("buyA_cv", 32'(n), 0);

    run_table(3, 5);
    send(8'h42);
    chk("buyB_item", 32'(item), 1);
    measure(w, n, c);
    chk("buyB_width", 32'(w), 4);
    chk("buyB_cv", 32'(n), 1);
    chk("buyB_change", 32'(c), 1);

    run_table(6, 7);
    send(8'h63);
    chk("cancel_cv", 32'(change_valid), 1);
    chk("cancel_change", 32'(change), 1);
    chk("cancel_credit", 32'(credit), 0);
    @(negedge clk);
    chk("cancel_cv_one", 32'(change_valid), 0);

    run_table(8, 19);
    send(8'h63);
    chk("cancel95_change", 32'(change), 95);
    chk("cancel95_cv", 32'(change_valid), 1);
    send(8'h63);
    chk("cancel0_err", 32'(error), 0);
    chk("cancel0_cv", 32'(change_valid), 0);
    chk("cancel0_credit", 32'(credit), 0);

    send(8'h35);
    send(8'h30);
    send(8'h41);
    chk("d_cycle1", 32'(dispense), 1);
    rx_byte = 8'h35;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("d_err5", 32'(error), 1);
    chk("d_cycle2", 32'(dispense), 1);
    rx_byte = 8'h7a;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("d_errz", 32'(error), 1);
    chk("d_cycle3", 32'(dispense), 1);
    @(negedge clk);
    chk("d_cycle4", 32'(dispense), 1);
    chk("d_err_clear", 32'(error), 0);
    @(negedge clk);
    chk("d_end", 32'(dispense), 0);
    chk("d_credit", 32'(credit), 0);
    chk("d_no_cv", 32'(change_valid), 0);

    send(8'h35);
    send(8'h30);
    send(8'h31);
    chk("pre_rst_credit", 32'(credit), 16);
    send(8'h41);
    @(negedge clk);
    chk("rst_mid_disp_before", 32'(dispense), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_dispense", 32'(dispense), 0);
    chk("rst_mid_credit", 32'(credit), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    w = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (change_valid) n++;
      if (dispense) w++;
    end
    chk("rst_mid_no_cv", 32'(n), 0);
    chk("rst_mid_no_disp", 32'(w), 0);

    send(8'h31);
    chk("echo1_credit", 32'(credit), 1);
`ifdef VEND_CMD_ECHO_EN
    chk("echo1_valid", 32'(tx_valid), 1);
    chk("echo1_byte", 32'(tx_byte), 32'h4B);
`endif
    send(8'h7a);
    chk("echoz_err", 32'(error), 1);
`ifdef VEND_CMD_ECHO_EN
    chk("echoz_valid", 32'(tx_valid), 1);
    chk("echoz_byte", 32'(tx_byte), 32'h45);
    @(negedge clk);
    chk("echo_idle", 32'(tx_valid), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_cmd_decoder.md
Name: vend_cmd_decoder

Overview:
- Downstream consumer of the UART receiver: turns each received ASCII byte into vending-machine actions.
- Actions: coin insertion, item selection, cancel/refund.
- Keeps the running credit, checks it against a fixed price, holds a timed dispense output, and reports change.
- Sits between the UART receive stage (rx_byte plus a one-cycle rx_valid strobe) and the machine's actuator/display logic.

Parameters:
- PRICE, 8'd15: item price in credit units.
- CREDIT_MAX, 8'd99: credit ceiling; coins that would exceed it are rejected.
- DISPENSE_CYCLES, 100_000_000: clk cycles dispense is held high (1 s at 100 MHz); must be ≥1.
- NUM_ITEMS, 4: selectable items, keys 'A' (0x41) upward.

Ports:
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: asynchronous, active-high reset.
- rx_byte, in, 8: received data byte.
- rx_valid, in, 1: one-cycle strobe; rx_byte is valid this cycle.
- credit, out, 8: current accumulated credit.
- dispense, out, 1: high for DISPENSE_CYCLES while an item is vended.
- item, out, 2: selected item index; valid while dispense is high.
- change, out, 8: refund amount; valid when change_valid is high.
- change_valid, out, 1: one-cycle strobe.
- error, out, 1: one-cycle strobe on a rejected or unknown byte.

Behaviour:
- Reset (async, immediate): credit=0, dispense=0, item=0, change=0, change_valid=0, error=0, state=IDLE, timer=0.
- All outputs are registered. A byte accepted on cycle N takes effect on cycle N+1.
- Key map:
  - '1' (0x31) adds 1.
  - '5' (0x35) adds 5.
  - '0' (0x30) adds 10.
  - 'A'..('A'+NUM_ITEMS-1) selects an item.
  - 'c' (0x63) cancels.
  - Any other byte pulses error.
- States: IDLE, DISPENSE, REFUND.
- IDLE, with rx_valid:
  - Coin: if credit+value ≤ CREDIT_MAX, credit += value. Otherwise credit is unchanged and error pulses. The sum is computed 9 bits wide, so it never wraps.
  - Select, credit ≥ PRICE: item ← index, change ← credit−PRICE, credit ← 0, dispense ← 1, timer ← 0, go to DISPENSE.
  - Select, credit < PRICE: error pulses, state unchanged.
  - Cancel, credit > 0: change ← credit, credit ← 0, go to REFUND.
  - Cancel, credit == 0: no action, no error.
- DISPENSE:
  - Timer counts every cycle.
  - When timer == DISPENSE_CYCLES−1: dispense ← 0, timer ← 0, then go to REFUND if change > 0, else IDLE.
  - Every rx_valid here is dropped and pulses error; credit is never modified.
- REFUND: change_valid pulses for exactly one cycle with change stable, then go to IDLE. An rx_valid arriving on this cycle is dropped with an error pulse.
- Exact-price purchase: no change_valid pulse.
- rx_valid is level-sampled each cycle. Two consecutive strobes are two bytes.
- Reset mid-DISPENSE aborts the vend; dispense drops immediately and pending change is lost.

Optional Feature:
- Macro: VEND_CMD_ECHO_EN.
- When defined, two extra ports are added:
  - tx_byte, out, 8
  - tx_valid, out, 1
- On the cycle after each rx_valid, tx_valid pulses with:
  - 'K' (0x4B) if the byte was accepted, including cancel with zero credit.
  - 'E' (0x45) if error fired.
- This feeds a UART transmitter for host acknowledgement. Both ports reset to 0.
- When not defined, the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - key constants: KEY_COIN1, KEY_COIN5, KEY_COIN10, KEY_SEL_BASE, KEY_CANCEL, ACK_OK, ACK_ERR;
  - the state enum vend_state_t (IDLE, DISPENSE, REFUND);
  - coin value constants.
- One sub-module is natural: vend_hold_timer, a parameterised down/up counter with start, done pulse and async reset, used for the dispense hold.

Test Plan (DISPENSE_CYCLES=4):
- Reset, then '5','5','5','A' → credit 5,10,15; dispense high 4 cycles with item=0; credit=0; no change_valid.
- '0','5','1','B' → credit 16; dispense 4 cycles with item=1; then change_valid for 1 cycle with change=1.
- '1','C' → error pulse on the 'C' cycle; credit stays 1. Then 'c' → change_valid with change=1; credit=0.
- Feed '0' ×9 (credit 90), then '0' → error; credit stays 90. Then '5' → 95.
- During a dispense, send '5' and 'z' → two error pulses; credit stays 0; dispense width exactly 4 cycles.
- Assert rst on the 2nd dispense cycle → dispense=0, credit=0 immediately; no change_valid afterwards. With VEND_CMD_ECHO_EN: the bytes '1','z' echo 'K','E'.
